// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC definitions for the filter-row receiver.
//   - packet field positions and widths
//   - noc_pkt_t: packed view of a 57-bit NoC packet
//   - rx_state_t: receiver control states
//   - unpack_pkt(): splits a raw packet into its fields
package noc_pkg;

   localparam int WIDTH_packet  = 57;
   localparam int WIDTH_payload = 40;
   localparam int WIDTH_data    = 8;

   localparam int SRC_HI     = 55;
   localparam int SRC_LO     = 52;
   localparam int DEST_HI    = 51;
   localparam int DEST_LO    = 48;
   localparam int XDIR       = 47;
   localparam int XHOP_HI    = 46;
   localparam int XHOP_LO    = 44;
   localparam int YDIR       = 43;
   localparam int YHOP_HI    = 42;
   localparam int YHOP_LO    = 40;
   localparam int PAYLOAD_HI = 39;
   localparam int PAYLOAD_LO = 0;

   typedef struct packed {
      logic                     spare;
      logic [3:0]               src;
      logic [3:0]               dest;
      logic                     xdir;
      logic [2:0]               xhop;
      logic                     ydir;
      logic [2:0]               yhop;
      logic [WIDTH_payload-1:0] payload;
   } noc_pkt_t;

   typedef enum logic [1:0] {
      EMPTY,
      LOADED,
      STREAM
   } rx_state_t;

   function automatic noc_pkt_t unpack_pkt(input logic [WIDTH_packet-1:0] raw);
      noc_pkt_t p;
      p.spare   = raw[WIDTH_packet-1];
      p.src     = raw[SRC_HI:SRC_LO];
      p.dest    = raw[DEST_HI:DEST_LO];
      p.xdir    = raw[XDIR];
      p.xhop    = raw[XHOP_HI:XHOP_LO];
      p.ydir    = raw[YDIR];
      p.yhop    = raw[YHOP_HI:YHOP_LO];
      p.payload = raw[PAYLOAD_HI:PAYLOAD_LO];
      return p;
   endfunction

endpackage

// File: rtl/pe_filter_rx.sv
// pe_filter_rx: destination-side receiver for filter-row packets.
// Accepts one NoC packet addressed to NODE, keeps its 40-bit payload as a
// filter row, and on stream_req replays the row one weight byte per
// handshake (tap 0 = payload LSB). The row is retained for replay.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     packet handshake from router ejection port
//   in_packet             57-bit NoC packet
//   stream_req            single-cycle request to replay the stored row
//   out_valid/out_ready   weight-byte handshake towards the PE
//   out_data, out_tap     current weight byte and its tap index
//   out_last              current byte is the final tap
//   stream_done           one-cycle pulse after the final tap is accepted
//   row_loaded, row_src   row-held flag and source of the last accepted row
//   pkt_count             accepted matching packets, modulo 256
//   err_misroute          sticky flag: a packet with a foreign dest arrived
module pe_filter_rx #(
   parameter int NODE          = 1,
   parameter int DEPTH_F       = 5,
   parameter int WIDTH_packet  = 57,
   parameter int WIDTH_payload = 40,
   parameter int WIDTH_data    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH_packet-1:0] in_packet,
   input  logic                    stream_req,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH_data-1:0]   out_data,
   output logic [2:0]              out_tap,
   output logic                    out_last,
   output logic                    stream_done,
   output logic                    row_loaded,
   output logic [3:0]              row_src,
   output logic [7:0]              pkt_count,
   output logic                    err_misroute
);
   import noc_pkg::*;

   if (WIDTH_payload != DEPTH_F * WIDTH_data) begin : g_width_chk
      $error("pe_filter_rx: WIDTH_payload must equal DEPTH_F*WIDTH_data");
   end

   rx_state_t                state_q, state_d;
   logic [2:0]               tap_q, tap_d;
   logic [WIDTH_payload-1:0] row_q, row_d;
   logic [3:0]               src_q, src_d;
   logic [7:0]               cnt_q, cnt_d;
   logic                     err_q, err_d;
   logic                     loaded_q, loaded_d;
   logic                     done_q, done_d;

   noc_pkt_t pkt;
   logic     pkt_fire;
   logic     dest_hit;
   logic     unused_route;

   assign pkt      = unpack_pkt(in_packet);
   assign dest_hit = (pkt.dest == 4'(NODE));
   assign pkt_fire = in_valid && in_ready;

   // Routing fields are only meaningful inside the mesh.
   assign unused_route = ^{pkt.spare, pkt.xdir, pkt.xhop, pkt.ydir, pkt.yhop};

   assign in_ready     = (state_q != STREAM);
   assign out_valid    = (state_q == STREAM);
   assign out_tap      = tap_q;
   assign out_data     = row_q[tap_q*WIDTH_data +: WIDTH_data];
   assign out_last     = (tap_q == 3'(DEPTH_F - 1));
   assign stream_done  = done_q;
   assign row_loaded   = loaded_q;
   assign row_src      = src_q;
   assign pkt_count    = cnt_q;
   assign err_misroute = err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         tap_q    <= '0;
         row_q    <= '0;
         src_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         loaded_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tap_q    <= tap_d;
         row_q    <= row_d;
         src_q    <= src_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         loaded_q <= loaded_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tap_d    = tap_q;
      row_d    = row_q;
      src_d    = src_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      loaded_d = loaded_q;
      done_d   = 1'b0;

      // Packet capture is independent of the control state so a reload and
      // a stream start in the same LOADED cycle both take effect; tap 0 then
      // already reads the new row.
      if (pkt_fire) begin
         if (dest_hit) begin
            row_d    = pkt.payload;
            src_d    = pkt.src;
            cnt_d    = cnt_q + 8'd1;
            loaded_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         EMPTY: begin
            if (pkt_fire && dest_hit) state_d = LOADED;
         end
         LOADED: begin
            if (stream_req) begin
               state_d = STREAM;
               tap_d   = '0;
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (out_last) begin
                  tap_d   = '0;
                  state_d = LOADED;
                  done_d  = 1'b1;
               end else begin
                  tap_d = tap_q + 3'd1;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

endmodule

// File: tb/tb_pe_filter_rx.sv
// tb_pe_filter_rx: directed table plus randomized run of pe_filter_rx
// against a queue-based reference model of the receiver.
module tb_pe_filter_rx;

   localparam int NODE = 3;
   localparam int NV   = 28;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [56:0] in_packet;
   logic        stream_req;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [2:0]  out_tap;
   logic        out_last;
   logic        stream_done;
   logic        row_loaded;
   logic [3:0]  row_src;
   logic [7:0]  pkt_count;
   logic        err_misroute;

   always #5 clk = ~clk;

   pe_filter_rx #(
      .NODE(NODE),
      .DEPTH_F(5),
      .WIDTH_packet(57),
      .WIDTH_payload(40),
      .WIDTH_data(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_packet(in_packet),
      .stream_req(stream_req),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_tap(out_tap),
      .out_last(out_last),
      .stream_done(stream_done),
      .row_loaded(row_loaded),
      .row_src(row_src),
      .pkt_count(pkt_count),
      .err_misroute(err_misroute)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the pending stream is a queue of bytes still to be
   // delivered; an empty queue means the receiver is not streaming.
   logic [39:0] m_row;
   logic        m_loaded;
   logic [3:0]  m_src;
   logic [7:0]  m_cnt;
   logic        m_err;
   logic        m_done;
   logic [7:0]  m_q[$];

   task automatic model_update();
      bit busy, had_row, done_n;
      if (!rst_n) begin
         m_row = '0; m_loaded = 0; m_src = '0; m_cnt = '0;
         m_err = 0; m_done = 0; m_q.delete();
      end else begin
         busy    = (m_q.size() != 0);
         had_row = m_loaded;
         done_n  = 0;
         if (busy && out_ready) begin
            void'(m_q.pop_front());
            done_n = (m_q.size() == 0);
         end
         if (in_valid && !busy) begin
            if (in_packet[51:48] == 4'(NODE)) begin
               m_row    = in_packet[39:0];
               m_src    = in_packet[55:52];
               m_cnt    = m_cnt + 8'd1;
               m_loaded = 1;
            end else begin
               m_err = 1;
            end
         end
         if (stream_req && !busy && had_row)
            for (int k = 0; k < 5; k++) m_q.push_back(m_row[8*k +: 8]);
         m_done = done_n;
      end
   endtask

   task automatic model_check();
      bit busy;
      busy = (m_q.size() != 0);
      check("in_ready", in_ready, !busy);
      check("out_valid", out_valid, busy);
      if (busy) begin
         check("out_data", out_data, m_q[0]);
         check("out_tap", out_tap, 5 - m_q.size());
         check("out_last", out_last, m_q.size() == 1);
      end
      check("stream_done", stream_done, m_done);
      check("row_loaded", row_loaded, m_loaded);
      check("row_src", row_src, m_src);
      check("pkt_count", pkt_count, m_cnt);
      check("err_misroute", err_misroute, m_err);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      model_check();
   endtask

   function automatic logic [56:0] mk_pkt(input logic [3:0] src, input logic [3:0] dest,
                                          input logic [39:0] pay);
      // bit 56 and hop bits set to junk: the receiver must ignore them
      return {1'b1, src, dest, 8'hA5, pay};
   endfunction

   typedef struct {
      bit          rst_n;
      bit          vld;
      logic [3:0]  src;
      logic [3:0]  dest;
      logic [39:0] pay;
      bit          sreq;
      bit          ordy;
      bit          e_rdy;
      bit          e_ov;
      logic [7:0]  e_data;
      logic [2:0]  e_tap;
      bit          e_last;
      bit          e_done;
      bit          e_err;
      bit          e_ld;
   } vec_t;

   function automatic vec_t mk(input bit r, input bit v, input logic [3:0] s, input logic [3:0] d,
                               input logic [39:0] p, input bit sq, input bit orr, input bit erdy,
                               input bit eov, input logic [7:0] ed, input logic [2:0] et,
                               input bit el, input bit edn, input bit eer, input bit eld);
      vec_t x;
      x.rst_n = r; x.vld = v; x.src = s; x.dest = d; x.pay = p; x.sreq = sq; x.ordy = orr;
      x.e_rdy = erdy; x.e_ov = eov; x.e_data = ed; x.e_tap = et; x.e_last = el;
      x.e_done = edn; x.e_err = eer; x.e_ld = eld;
      return x;
   endfunction

   vec_t tbl[NV];

   initial begin
      logic [39:0] P, Q;
      logic [63:0] r64;
      logic [56:0] pk;
      P = 40'h0504030201;
      Q = 40'hAABBCCDDEE;

      //            rst vld src dst pay sreq ordy | rdy ov data tap last done err ld
      tbl[0]  = mk(1, 1, 11, 3, P,  0, 1,  1, 0, 8'h00, 0, 0, 0, 0, 1);
      tbl[1]  = mk(1, 0,  0, 0, 0,  1, 1,  0, 1, 8'h01, 0, 0, 0, 0, 1);
      tbl[2]  = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'h02, 1, 0, 0, 0, 1);
      tbl[3]  = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'h03, 2, 0, 0, 0, 1);
      tbl[4]  = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'h04, 3, 0, 0, 0, 1);
      tbl[5]  = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'h05, 4, 1, 0, 0, 1);
      tbl[6]  = mk(1, 0,  0, 0, 0,  0, 1,  1, 0, 8'h00, 0, 0, 1, 0, 1);
      tbl[7]  = mk(1, 0,  0, 0, 0,  0, 1,  1, 0, 8'h00, 0, 0, 0, 0, 1);
      tbl[8]  = mk(1, 1,  7, 4, Q,  0, 1,  1, 0, 8'h00, 0, 0, 0, 1, 1);
      tbl[9]  = mk(1, 0,  0, 0, 0,  1, 1,  0, 1, 8'h01, 0, 0, 0, 1, 1);
      tbl[10] = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'h02, 1, 0, 0, 1, 1);
      tbl[11] = mk(1, 0,  0, 0, 0,  0, 0,  0, 1, 8'h02, 1, 0, 0, 1, 1);
      tbl[12] = mk(1, 1,  9, 3, Q,  0, 0,  0, 1, 8'h02, 1, 0, 0, 1, 1);
      tbl[13] = mk(1, 1,  9, 3, Q,  0, 1,  0, 1, 8'h03, 2, 0, 0, 1, 1);
      tbl[14] = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'h04, 3, 0, 0, 1, 1);
      tbl[15] = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'h05, 4, 1, 0, 1, 1);
      tbl[16] = mk(1, 0,  0, 0, 0,  0, 1,  1, 0, 8'h00, 0, 0, 1, 1, 1);
      tbl[17] = mk(1, 1,  5, 3, Q,  1, 1,  0, 1, 8'hEE, 0, 0, 0, 1, 1);
      tbl[18] = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'hDD, 1, 0, 0, 1, 1);
      tbl[19] = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'hCC, 2, 0, 0, 1, 1);
      tbl[20] = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'hBB, 3, 0, 0, 1, 1);
      tbl[21] = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'hAA, 4, 1, 0, 1, 1);
      tbl[22] = mk(1, 0,  0, 0, 0,  0, 1,  1, 0, 8'h00, 0, 0, 1, 1, 1);
      tbl[23] = mk(1, 0,  0, 0, 0,  1, 1,  0, 1, 8'hEE, 0, 0, 0, 1, 1);
      tbl[24] = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'hDD, 1, 0, 0, 1, 1);
      tbl[25] = mk(1, 0,  0, 0, 0,  0, 1,  0, 1, 8'hCC, 2, 0, 0, 1, 1);
      tbl[26] = mk(0, 0,  0, 0, 0,  0, 1,  1, 0, 8'h00, 0, 0, 0, 0, 0);
      tbl[27] = mk(1, 0,  0, 0, 0,  0, 1,  1, 0, 8'h00, 0, 0, 0, 0, 0);

      rst_n = 1'b0; in_valid = 1'b0; in_packet = '0; stream_req = 1'b0; out_ready = 1'b0;
      step();
      step();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_row_loaded", row_loaded, 0);
      check("rst_pkt_count", pkt_count, 0);
      check("rst_err", err_misroute, 0);
      check("rst_done", stream_done, 0);

      for (int i = 0; i < NV; i++) begin
         rst_n      = tbl[i].rst_n;
         in_valid   = tbl[i].vld;
         in_packet  = mk_pkt(tbl[i].src, tbl[i].dest, tbl[i].pay);
         stream_req = tbl[i].sreq;
         out_ready  = tbl[i].ordy;
         step();
         check($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_rdy);
         check($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
         if (tbl[i].e_ov) begin
            check($sformatf("v%0d_out_data", i), out_data, tbl[i].e_data);
            check($sformatf("v%0d_out_tap", i), out_tap, tbl[i].e_tap);
            check($sformatf("v%0d_out_last", i), out_last, tbl[i].e_last);
         end
         check($sformatf("v%0d_stream_done", i), stream_done, tbl[i].e_done);
         check($sformatf("v%0d_err", i), err_misroute, tbl[i].e_err);
         check($sformatf("v%0d_row_loaded", i), row_loaded, tbl[i].e_ld);
         if (i == 7 || i == 16) begin
            check($sformatf("v%0d_row_src", i), row_src, 11);
            check($sformatf("v%0d_pkt_count", i), pkt_count, 1);
         end
         if (i == 22) begin
            check("v22_row_src", row_src, 5);
            check("v22_pkt_count", pkt_count, 2);
         end
      end

      for (int c = 0; c < 4000; c++) begin
         rst_n      = ($urandom_range(0, 299) != 0);
         in_valid   = ($urandom_range(0, 9) < 4);
         r64        = {$urandom(), $urandom()};
         pk         = r64[56:0];
         if ($urandom_range(0, 1) == 1) pk[51:48] = 4'(NODE);
         in_packet  = pk;
         stream_req = ($urandom_range(0, 4) == 0);
         out_ready  = ($urandom_range(0, 9) < 7);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pe_filter_rx.md
Name: pe_filter_rx

Overview:
- Destination-side receiver for filter-row packets that the filter memory node injects into the NoC.
- Sits between the local router's ejection port and a PE's MAC datapath.
- Accepts one 57-bit packet, checks that it is addressed to this node, and latches the 40-bit filter row.
- On request, streams the DEPTH_F weight bytes to the PE, one per handshake. The row is retained, so it can be replayed for every convolution window.

Parameters:
- NODE, 1, 1-based node ID; compared against packet dest field [51:48].
- DEPTH_F, 5, taps per filter row.
- WIDTH_packet, 57, NoC packet width.
- WIDTH_payload, 40, payload width. Must equal DEPTH_F*WIDTH_data; an elaboration-time check enforces this.
- WIDTH_data, 8, weight width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- in_valid  in  1  packet valid from router ejection port
- in_ready  out  1  receiver can accept a packet
- in_packet  in  WIDTH_packet  [55:52] src, [51:48] dest, [47] xdir, [46:44] xhop, [43] ydir, [42:40] yhop, [39:0] payload
- stream_req  in  1  single-cycle request to stream the stored row
- out_valid  out  1  weight byte valid
- out_ready  in  1  PE accepts weight
- out_data  out  WIDTH_data  weight byte
- out_tap  out  3  tap index 0..DEPTH_F-1
- out_last  out  1  current byte is tap DEPTH_F-1
- stream_done  out  1  one-cycle pulse after the last tap is accepted
- row_loaded  out  1  a valid row is held
- row_src  out  4  source field of the last accepted packet
- pkt_count  out  8  accepted matching packets (wraps modulo 256)
- err_misroute  out  1  sticky: a packet arrived with dest != NODE

Behaviour:
- Reset (rst_n=0 at a rising edge): state=EMPTY.
  - row_reg=0, tap=0, row_src=0, pkt_count=0.
  - err_misroute=0, stream_done=0, out_valid=0, row_loaded=0.
  - Reset overrides everything; asserting it mid-stream aborts the stream with no stream_done.
- Accept rule: a packet transfers on a rising edge with in_valid && in_ready.
  - in_ready=1 in EMPTY and LOADED; in_ready=0 in STREAM.
- Dest match (in_packet[51:48]==NODE):
  - row_reg<=payload[39:0], row_src<=[55:52], pkt_count+=1, row_loaded<=1, state EMPTY->LOADED.
- Dest mismatch: packet consumed and dropped, err_misroute<=1, no other state change.
- Hop/direction fields and bit 56 are ignored.
- States:
  - EMPTY: stream_req is ignored. A matching packet moves to LOADED.
  - LOADED: a matching packet overwrites the row (reload). stream_req moves to STREAM with tap<=0.
  - STREAM: out_valid=1, out_data=row_reg[tap*8 +: 8], out_tap=tap, out_last=(tap==DEPTH_F-1).
    - On out_valid && out_ready: if !out_last, tap+=1; else tap<=0, state<=LOADED, stream_done<=1 for the next cycle.
    - stream_req during STREAM is ignored (not queued).
- out_valid is a registered state decode; the first byte is valid in the cycle after stream_req is sampled.
- out_data and out_tap hold stable while out_valid && !out_ready.
- Simultaneous matching packet and stream_req in LOADED: both take effect. The row is written and STREAM is entered, so tap 0 already shows the new row.
- Simultaneous packet and stream_req in EMPTY: the packet is accepted; stream_req is dropped.
- Byte order: tap k = payload[8k+7:8k], so tap 0 is the LSB.
- Throughput: DEPTH_F cycles per stream with out_ready held high; back-to-back stream_req is accepted in the cycle stream_done is high.

Decomposition:
- Package noc_pkg holds:
  - field constants: SRC_HI/LO=55/52, DEST_HI/LO=51/48, XDIR=47, XHOP 46:44, YDIR=43, YHOP 42:40, PAYLOAD 39:0;
  - WIDTH_packet, WIDTH_payload, WIDTH_data;
  - packed struct noc_pkt_t;
  - enum rx_state_t {EMPTY, LOADED, STREAM}.
- No sub-module; field extraction is a package function, not a separate module.

Test Plan:
- Reset, then check outputs: in_ready=1, out_valid=0, row_loaded=0, pkt_count=0, err_misroute=0.
- NODE=3; send src=11, dest=3, payload 40'h0504030201; pulse stream_req with out_ready=1 -> out_data 01,02,03,04,05 on tap 0..4 in consecutive cycles; out_last on tap 4; stream_done one cycle later; row_src=11, pkt_count=1.
- Packet with dest=4 -> dropped; err_misroute=1 and stays set; row_reg, row_src and pkt_count unchanged.
- During STREAM, toggle out_ready 1,0,0,1 -> out_data/out_tap hold while stalled; in_ready=0 throughout; a packet presented mid-stream is not accepted until LOADED.
- In LOADED, drive packet payload 40'hAABBCCDDEE and stream_req in the same cycle -> stream outputs EE,DD,CC,BB,AA.
- Assert rst_n=0 at tap 2 -> next cycle out_valid=0, state EMPTY, no stream_done, row_loaded=0.
